stream_buffer: RTL and testbench
================================

STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, storage entries (power of two, >=2).
REQ-003 SHALL have parameter FALLTHROUGH, default 0: 0 = registered output, 1 = empty-buffer bypass.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of stored contents.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  buffer can accept.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port out_valid  output  1  downstream payload valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready; a transfer occurs only on a cycle with the corresponding handshake.
REQ-015 SHALL drive in_ready = !rst & !flush & (count < DEPTH); in_ready SHALL NOT depend combinationally on out_ready.
REQ-016 With FALLTHROUGH=0, SHALL drive out_valid = !flush & (count != 0) and out_data = head entry.
REQ-017 With FALLTHROUGH=0, SHALL present a word pushed into an empty buffer on out_valid exactly one cycle after its push (latency 1).
REQ-018 With FALLTHROUGH=1 and count==0, SHALL drive out_valid = in_valid & !flush & !rst and out_data = in_data (latency 0).
REQ-019 With FALLTHROUGH=1, count==0, and push & pop in the same cycle, SHALL bypass the word without storing it; count stays 0.
REQ-020 With count!=0, SHALL always drive out_data from storage, never from in_data, in both modes.
REQ-021 SHALL deliver words in strict push order, with no loss or duplication.
REQ-022 SHALL hold out_data and out_valid stable while out_valid & !out_ready, unless flush or rst is asserted.
REQ-023 Count update: push only: +1; pop only: -1; push & pop from storage: unchanged (head advances, tail written); bypass (REQ-019): unchanged.
REQ-024 SHALL wrap the write and read pointers modulo DEPTH.
REQ-025 When full (count==DEPTH), in_ready SHALL be 0; a pop in that cycle SHALL raise in_ready on the next cycle.
REQ-026 flush SHALL set count, read pointer and write pointer to 0 at the next edge; in that cycle no push or pop occurs, because in_ready=0 and out_valid=0.
REQ-027 SHALL give flush and rst priority over any handshake in the same cycle.
REQ-028 SHALL never overflow or underflow by construction; count SHALL stay within 0..DEPTH.

Reset
REQ-029 While rst=1: in_ready=0, out_valid=0, count=0; at the edge, both pointers SHALL become 0.
REQ-030 On the first cycle after rst deasserts: in_ready=1, out_valid=0 (FALLTHROUGH=1: out_valid follows in_valid), count=0.
REQ-031 Storage contents need not be reset; out_data is don't-care while out_valid=0.
REQ-032 rst asserted mid-stream SHALL discard all stored words; no pre-reset word SHALL appear after reset.

Verification (WIDTH=32, DEPTH=4 unless stated)
REQ-033 SHALL cover: FALLTHROUGH=0, push 0xA5A5_0001 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1; data held stable for 3 stalled cycles.
REQ-034 SHALL cover: push 0x1..0x4 with out_ready=0 -> count=4, in_ready=0; 0x5 is offered and not accepted; one pop -> in_ready=1 the next cycle, then 0x5 is accepted; drain order is 0x1,0x2,0x3,0x4,0x5.
REQ-035 SHALL cover: continuous push & pop with count=2 for 10 cycles of values 0x10..0x19 -> count constant at 2; outputs in order; pointers wrap at least twice.
REQ-036 SHALL cover: FALLTHROUGH=1, empty, in_valid=1, in_data=0xDEAD_BEEF, out_ready=1 -> same cycle out_valid=1, out_data=0xDEAD_BEEF; count stays 0.
REQ-037 SHALL cover: count=3, assert flush with in_valid=1 and out_ready=1 -> no transfer that cycle; next cycle count=0, out_valid=0, in_ready=1.
REQ-038 SHALL cover: count=2, assert rst for 1 cycle -> count=0, out_valid=0; after release, the next pushed word 0x77 is the first word output.

Source files
------------

// File: rtl/stream_buffer.sv
// Valid/ready FIFO stream buffer with power-of-two storage.
// Registered output by default, or empty-buffer bypass when FALLTHROUGH=1.
module stream_buffer #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter bit FALLTHROUGH = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    assign w_empty  = (r_count == '0);
    assign in_ready = !rst && !flush && (r_count != FULL);

    generate
        if (FALLTHROUGH) begin : g_ft
            assign out_valid = !rst && !flush && (w_empty ? in_valid : 1'b1);
            assign out_data  = w_empty ? in_data : r_mem[r_rptr];
        end else begin : g_reg
            assign out_valid = !rst && !flush && !w_empty;
            assign out_data  = r_mem[r_rptr];
        end
    endgenerate

    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    // Only reachable in bypass mode: an empty buffer never pops otherwise.
    assign w_bypass = w_empty && w_push && w_pop;
    assign w_wr     = w_push && !w_bypass;
    assign w_rd     = w_pop && !w_empty;

    assign count = rst ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_buffer.sv
// Bench for stream_buffer: queue model for both output modes
// plus directed scenarios with literal expectations.
module tb_stream_buffer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        ir0, ov0, ir1, ov1;
    logic [31:0] od0, od1;
    logic [2:0]  c0, c1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];

    stream_buffer #(.WIDTH(32), .DEPTH(D), .FALLTHROUGH(1'b0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .count(c0)
    );

    stream_buffer #(.WIDTH(32), .DEPTH(D), .FALLTHROUGH(1'b1)) u_ft (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .count(c1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each buffer is just an ordered queue of stored words.
    always @(posedge clk) begin
        bit p, o;
        if (rst || flush) begin
            q0.delete();
            q1.delete();
        end else begin
            p = in_valid && (q0.size() < D);
            o = (q0.size() != 0) && out_ready;
            if (o) void'(q0.pop_front());
            if (p) q0.push_back(in_data);
            if (q1.size() == 0) begin
                if (in_valid && !out_ready) q1.push_back(in_data);
            end else begin
                p = in_valid && (q1.size() < D);
                o = out_ready;
                if (o) void'(q1.pop_front());
                if (p) q1.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        bit          eir0, eov0, eir1, eov1;
        logic [31:0] eod0, eod1;
        eir0 = !rst && !flush && (q0.size() < D);
        eov0 = !rst && !flush && (q0.size() != 0);
        eod0 = (q0.size() != 0) ? q0[0] : 32'h0;
        eir1 = !rst && !flush && (q1.size() < D);
        if (q1.size() == 0) begin
            eov1 = !rst && !flush && in_valid;
            eod1 = in_data;
        end else begin
            eov1 = !rst && !flush;
            eod1 = q1[0];
        end
        chk("m_in_ready0", 32'(ir0), 32'(eir0));
        chk("m_out_valid0", 32'(ov0), 32'(eov0));
        chk("m_count0", 32'(c0), rst ? 32'd0 : 32'(q0.size()));
        if (eov0) chk("m_out_data0", od0, eod0);
        chk("m_in_ready1", 32'(ir1), 32'(eir1));
        chk("m_out_valid1", 32'(ov1), 32'(eov1));
        chk("m_count1", 32'(c1), rst ? 32'd0 : 32'(q1.size()));
        if (eov1) chk("m_out_data1", od1, eod1);
        if (ov0 && out_ready) log0.push_back(od0);
        if (ov1 && out_ready) log1.push_back(od1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] e;
        tick();
        tick();
        at_neg();
        chk("rst_count", 32'(c0), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd0);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_valid_ft", 32'(ov1), 32'd0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("post_rst_in_ready", 32'(ir0), 32'd1);
        chk("post_rst_out_valid", 32'(ov0), 32'd0);
        chk("post_rst_count", 32'(c0), 32'd0);
        tick();

        // Single word, latency 1, held under stall
        in_valid = 1'b1;
        in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("lat1_valid", 32'(ov0), 32'd1);
        chk("lat1_data", od0, 32'hA5A5_0001);
        chk("lat1_count", 32'(c0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            at_neg();
            chk("stall_valid", 32'(ov0), 32'd1);
            chk("stall_data", od0, 32'hA5A5_0001);
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat1_drain_n", 32'(log0.size()), 32'd1);
        chk("lat1_drain_w", log0[0], 32'hA5A5_0001);
        log0.delete();
        log1.delete();

        // Fill to full, backpressure, then drain
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'(i);
            tick();
        end
        in_data = 32'h5;
        at_neg();
        chk("full_count", 32'(c0), 32'd4);
        chk("full_in_ready", 32'(ir0), 32'd0);
        tick();
        at_neg();
        chk("full_reject", 32'(c0), 32'd4);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        at_neg();
        chk("unfull_in_ready", 32'(ir0), 32'd1);
        chk("unfull_count", 32'(c0), 32'd3);
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("refull_count", 32'(c0), 32'd4);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        chk("full_drain_n", 32'(log0.size()), 32'd5);
        for (int i = 0; i < 5 && i < log0.size(); i++)
            chk("full_drain_w", log0[i], 32'(i + 1));
        log0.delete();
        log1.delete();

        // Steady push & pop at count 2, pointers wrap
        in_valid = 1'b1;
        in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h10 + 32'(i);
            at_neg();
            chk("steady_count", 32'(c0), 32'd2);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        chk("steady_n", 32'(log0.size()), 32'd12);
        for (int i = 0; i < 12 && i < log0.size(); i++) begin
            e = (i < 2) ? 32'hA0 + 32'(i) : 32'h10 + 32'(i - 2);
            chk("steady_w", log0[i], e);
        end
        chk("steady_n_ft", 32'(log1.size()), 32'd12);
        log0.delete();
        log1.delete();

        // Flush with count 3 and both handshakes offered
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h31 + 32'(i);
            tick();
        end
        flush = 1'b1;
        in_data = 32'h34;
        out_ready = 1'b1;
        at_neg();
        chk("flush_in_ready", 32'(ir0), 32'd0);
        chk("flush_out_valid", 32'(ov0), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        at_neg();
        chk("flush_count", 32'(c0), 32'd0);
        chk("flush_out_valid2", 32'(ov0), 32'd0);
        chk("flush_in_ready2", 32'(ir0), 32'd1);
        tick();
        chk("flush_no_xfer", 32'(log0.size()), 32'd0);

        // Bypass on the fall-through instance
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        at_neg();
        chk("bypass_valid", 32'(ov1), 32'd1);
        chk("bypass_data", od1, 32'hDEAD_BEEF);
        chk("bypass_count", 32'(c1), 32'd0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        at_neg();
        chk("bypass_count2", 32'(c1), 32'd0);
        chk("bypass_reg_count", 32'(c0), 32'd1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-stream
        in_valid = 1'b1;
        in_data = 32'h51;
        tick();
        in_data = 32'h52;
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("pre_rst_count", 32'(c0), 32'd2);
        tick();
        rst = 1'b1;
        at_neg();
        chk("mid_rst_count", 32'(c0), 32'd0);
        chk("mid_rst_valid", 32'(ov0), 32'd0);
        chk("mid_rst_in_ready", 32'(ir0), 32'd0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("after_rst_count", 32'(c0), 32'd0);
        chk("after_rst_valid", 32'(ov0), 32'd0);
        tick();
        log0.delete();
        in_valid = 1'b1;
        in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("after_rst_n", 32'(log0.size()), 32'd1);
        chk("after_rst_w", log0[0], 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
